trans_mutex_arbiter: RTL

// - Shares one transactor (do_work/op_code/work_done handshake) between NUM_REQ requesters.
// - Round-robin arbitration with mutex-style lock: an owner may issue back-to-back ops without re-arbitrating.
// - Sits between test-side requester ports and a single transactor instance; replaces ad-hoc software mutexing.

---
 rtl/trans_mutex_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/trans_mutex_arbiter.sv
// Round-robin arbiter with a lockable owner that shares one do_work/work_done transactor among NUM_REQ requesters.
// Grant comes 1 cycle after req and do_work 1 cycle after grant; define TRANS_ARB_STATS_EN to add saturating done_count counters.
module trans_mutex_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 11,
  parameter int OWN_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_lock,
  input  logic [NUM_REQ*OP_W-1:0]  i_op_code_in,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_do_work,
  output logic [OP_W-1:0]          o_op_code,
  input  logic                     i_work_done,
  output logic                     o_busy,
`ifdef TRANS_ARB_STATS_EN
  output logic [NUM_REQ*CNT_W-1:0] o_done_count,
`endif
  output logic [OWN_W-1:0]         o_owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_do_work;
  logic [OP_W-1:0]      r_op;
  logic [OWN_W-1:0]     r_owner;
  logic [OWN_W-1:0]     r_ptr;
  logic                 r_wd_q;

  logic                 w_any;
  logic                 w_has_after;
  logic [OWN_W-1:0]     w_first;
  logic [OWN_W-1:0]     w_after;
  logic [OWN_W-1:0]     w_win;
  logic [OP_W-1:0]      w_win_op;
  logic [OP_W-1:0]      w_own_op;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic                 w_rise;

  // Round robin: lowest request above the pointer, else lowest request overall (wrap).
  always_comb begin
    w_any       = 1'b0;
    w_has_after = 1'b0;
    w_first     = '0;
    w_after     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_any   = 1'b1;
        w_first = OWN_W'(i);
        if (i > int'(r_ptr)) begin
          w_has_after = 1'b1;
          w_after     = OWN_W'(i);
        end
      end
    end
    w_win = w_has_after ? w_after : w_first;
  end

  assign w_win_op     = i_op_code_in[int'(w_win) * OP_W +: OP_W];
  assign w_own_op     = i_op_code_in[int'(r_owner) * OP_W +: OP_W];
  assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_rise       = i_work_done & ~r_wd_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_do_work <= 1'b0;
      r_op      <= '0;
      r_owner   <= '0;
      r_ptr     <= OWN_W'(NUM_REQ - 1);
      r_wd_q    <= 1'b0;
    end else begin
      r_wd_q <= i_work_done;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_win_onehot;
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_op    <= w_win_op;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_do_work <= 1'b1;
          r_state   <= WAIT;
        end
        WAIT: begin
          r_do_work <= 1'b0;
          // A level already high when the op was issued is not a completion.
          if (w_rise) begin
            r_done <= r_grant;
            if (i_lock[r_owner]) begin
              r_state <= HOLD;
            end else begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (i_req[r_owner]) begin
            r_op    <= w_own_op;
            r_state <= ISSUE;
          end else if (!i_lock[r_owner]) begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_do_work = r_do_work;
  assign o_op_code = r_op;
  assign o_busy    = (r_state != IDLE);
  assign o_owner   = r_owner;

`ifdef TRANS_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_cnt[g] <= '0;
      end else if (r_done[g] && (r_cnt[g] != {CNT_W{1'b1}})) begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
    assign o_done_count[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule
